// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT subset: register offsets within the
// CLINT window and the MCAUSE interrupt codes the exception unit uses when
// it takes the software or timer interrupt.
package clint_pkg;

    // Byte offsets of the 32-bit registers inside the CLINT window
    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    // MCAUSE exception codes (interrupt bit set separately by the core)
    localparam logic [3:0] MCAUSE_MSI = 4'd3;
    localparam logic [3:0] MCAUSE_MTI = 4'd7;

    // Reset value of mtimecmp: never matches, so no timer interrupt at boot
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk down to the mtime increment rate.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   tick : high for one cycle every PRESCALE cycles (every cycle if PRESCALE=1)
module clint_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Tick is asserted while the counter sits at its last value
    assign tick  = (cnt_q == 16'(PRESCALE - 1));
    assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer and software interrupt source (CLINT subset).
//   clk, rst           : clock, asynchronous active-high reset
//   mem_req/we/addr    : single-cycle bus request, byte offset in the window
//   mem_wdata          : full-word write data
//   mem_rdata/ack/err  : registered response, one cycle after the request
//   msip_irq, mtip_irq : registered pending bits
//   interrupt          : OR of the two pending bits
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              msip_irq,
    output logic              mtip_irq,
    output logic              interrupt
);

    logic        tick;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, err_q, mtip_q;
    logic        ack_d, err_d, mtip_d;

    logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic acc_err, wr_ok;
    logic [31:0] rd_val;

    clint_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Address decode; upper offset bits beyond 16 must be zero to hit
    assign sel_msip   = (mem_addr == ADDR_W'(CLINT_MSIP));
    assign sel_cmp_lo = (mem_addr == ADDR_W'(CLINT_MTIMECMP_LO));
    assign sel_cmp_hi = (mem_addr == ADDR_W'(CLINT_MTIMECMP_HI));
    assign sel_mt_lo  = (mem_addr == ADDR_W'(CLINT_MTIME_LO));
    assign sel_mt_hi  = (mem_addr == ADDR_W'(CLINT_MTIME_HI));

    assign acc_err = (mem_addr[1:0] != 2'b00) ||
                     !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_mt_lo || sel_mt_hi);
    assign wr_ok   = mem_req && mem_we && !acc_err;

    always_comb begin
        rd_val = 32'd0;
        if (sel_msip)   rd_val = {31'd0, msip_q};
        if (sel_cmp_lo) rd_val = mtimecmp_q[31:0];
        if (sel_cmp_hi) rd_val = mtimecmp_q[63:32];
        if (sel_mt_lo)  rd_val = mtime_q[31:0];
        if (sel_mt_hi)  rd_val = mtime_q[63:32];
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        if (wr_ok && sel_msip)   msip_d = mem_wdata[0];
        if (wr_ok && sel_cmp_lo) mtimecmp_d[31:0]  = mem_wdata;
        if (wr_ok && sel_cmp_hi) mtimecmp_d[63:32] = mem_wdata;

        // A half-write overrides the tick for that half and blocks any carry
        // between halves; the low half still counts when only HI is written.
        if (wr_ok && sel_mt_lo)  mtime_d = {mtime_q[63:32], mem_wdata};
        if (wr_ok && sel_mt_hi)  mtime_d = {mem_wdata, mtime_q[31:0] + {31'd0, tick}};

        ack_d   = mem_req;
        err_d   = mem_req && acc_err;
        rdata_d = (mem_req && !mem_we && !acc_err) ? rd_val : 32'd0;

        // Compared on current register values, so a mtimecmp write
        // reaches mtip_irq two cycles after its request
        mtip_d  = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= MTIMECMP_RST;
            mtime_q    <= 64'd0;
            rdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ack   = ack_q;
    assign mem_err   = err_q;
    assign msip_irq  = msip_q;
    assign mtip_irq  = mtip_q;
    assign interrupt = msip_q | mtip_q;

endmodule
